// File: rtl/usb_tcpc_pkg.sv
// Shared TCPC definitions: register map, ALERT bit positions and receive-buffer state encodings.
package usb_tcpc_pkg;

    localparam logic [7:0] REG_RECEIVE_BYTE_COUNT = 8'h30;
    localparam logic [7:0] REG_RX_BUF_FRAME_TYPE  = 8'h31;

    localparam int ALERT_RX_STATUS_BIT   = 2;
    localparam int ALERT_RX_OVERFLOW_BIT = 10;

    localparam int RX_BUF_DEPTH = 31;

    typedef enum logic [2:0] {
        ST_EMPTY   = 3'b001,
        ST_FILLING = 3'b010,
        ST_LOCKED  = 3'b100
    } rx_buf_state_t;

    typedef enum logic [1:0] {
        RD_SEL_ZERO  = 2'd0,
        RD_SEL_COUNT = 2'd1,
        RD_SEL_RAM   = 2'd2
    } rx_rd_sel_t;

endpackage

// File: rtl/rx_buffer_ram.sv
// DEPTH x 8 receive storage: one synchronous write port, one registered read port (read-before-write).
module rx_buffer_ram #(
    parameter int DEPTH  = 31,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/usb_rx_buffer.sv
// USB Type-C receive buffer with byte count, status and overflow flags.
// Optional RX_BUF_AUTO_RELEASE_EN: reading the last stored byte of a locked message releases it.
//
// state      | meaning
// ST_EMPTY   | no message bytes stored
// ST_FILLING | message in progress, writes accepted
// ST_LOCKED  | complete message held, writes rejected until released
module usb_rx_buffer
    import usb_tcpc_pkg::*;
#(
    parameter int         DEPTH     = RX_BUF_DEPTH,
    parameter logic [7:0] BASE_ADDR = REG_RX_BUF_FRAME_TYPE
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       iWR_EN,
    input  logic [7:0] iDIR_WRITE,
    input  logic [7:0] iDATA,
    input  logic       iMSG_END,
    input  logic       iRD_EN,
    input  logic [7:0] iDIR_READ,
    input  logic       iCLEAR,
    output logic [7:0] oDATA_READ,
    output logic       oRD_VALID,
    output logic [7:0] oRECEIVE_BYTE_COUNT,
    output logic       oRX_STATUS,
    output logic       oRX_OVERFLOW,
    output logic       oBUF_LOCKED
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    rx_buf_state_t state_q;
    rx_rd_sel_t    rd_sel_q;
    logic [7:0]    count_q;
    logic [7:0]    rd_count_q;
    logic [7:0]    ram_rd_data;
    logic          rx_status_q;
    logic          overflow_q;
    logic          rd_valid_q;

    logic [7:0] wr_offset;
    logic [7:0] rd_offset;
    logic [7:0] wr_end;
    logic [7:0] count_next;
    logic       wr_in_range;
    logic       rd_in_range;
    logic       auto_release;
    logic       clear_eff;
    logic       wr_accept;
    logic       wr_reject;

    assign wr_offset   = iDIR_WRITE - BASE_ADDR;
    assign rd_offset   = iDIR_READ - BASE_ADDR;
    assign wr_in_range = (wr_offset < DEPTH8);
    assign rd_in_range = (rd_offset < count_q);

`ifdef RX_BUF_AUTO_RELEASE_EN
    assign auto_release = (state_q == ST_LOCKED) && iRD_EN && (count_q != 8'd0)
                          && (rd_offset == count_q - 8'd1);
`else
    assign auto_release = 1'b0;
`endif

    // Clear wins over any same-cycle write or message end.
    assign clear_eff = iCLEAR || auto_release;
    assign wr_accept = iWR_EN && wr_in_range && (state_q != ST_LOCKED) && !clear_eff;
    assign wr_reject = iWR_EN && (!wr_in_range || (state_q == ST_LOCKED)) && !clear_eff;

    assign wr_end     = wr_offset + 8'd1;
    assign count_next = (wr_end > count_q) ? ((wr_end > DEPTH8) ? DEPTH8 : wr_end) : count_q;

    rx_buffer_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .CLK     (CLK),
        .wr_en   (wr_accept),
        .wr_addr (wr_offset[ADDR_W-1:0]),
        .wr_data (iDATA),
        .rd_en   (iRD_EN && rd_in_range),
        .rd_addr (rd_offset[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            count_q     <= 8'd0;
            rx_status_q <= 1'b0;
            overflow_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= RD_SEL_ZERO;
            rd_count_q  <= 8'd0;
        end else begin
            rd_valid_q <= iRD_EN;
            if (iRD_EN) begin
                rd_count_q <= count_q;
                if (iDIR_READ == BASE_ADDR - 8'd1) begin
                    rd_sel_q <= RD_SEL_COUNT;
                end else if (rd_in_range) begin
                    rd_sel_q <= RD_SEL_RAM;
                end else begin
                    rd_sel_q <= RD_SEL_ZERO;
                end
            end

            if (clear_eff) begin
                state_q     <= ST_EMPTY;
                count_q     <= 8'd0;
                rx_status_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (wr_accept) begin
                    count_q <= count_next;
                end
                if (wr_reject) begin
                    overflow_q <= 1'b1;
                end
                case (state_q)
                    ST_EMPTY: begin
                        // A message end with nothing written leaves the buffer empty.
                        if (wr_accept && iMSG_END) begin
                            state_q     <= ST_LOCKED;
                            rx_status_q <= 1'b1;
                        end else if (wr_accept) begin
                            state_q <= ST_FILLING;
                        end
                    end
                    ST_FILLING: begin
                        if (iMSG_END) begin
                            state_q     <= ST_LOCKED;
                            rx_status_q <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        state_q <= ST_LOCKED;
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    always_comb begin
        oDATA_READ = 8'h00;
        case (rd_sel_q)
            RD_SEL_COUNT: oDATA_READ = rd_count_q;
            RD_SEL_RAM:   oDATA_READ = ram_rd_data;
            default:      oDATA_READ = 8'h00;
        endcase
    end

    assign oRD_VALID           = rd_valid_q;
    assign oRECEIVE_BYTE_COUNT = count_q;
    assign oRX_STATUS          = rx_status_q;
    assign oRX_OVERFLOW        = overflow_q;
    assign oBUF_LOCKED         = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_usb_rx_buffer.sv
// Directed self-checking bench for usb_rx_buffer; covers RX_BUF_AUTO_RELEASE_EN when defined.
module tb_usb_rx_buffer;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       iWR_EN = 1'b0;
    logic [7:0] iDIR_WRITE = 8'h00;
    logic [7:0] iDATA = 8'h00;
    logic       iMSG_END = 1'b0;
    logic       iRD_EN = 1'b0;
    logic [7:0] iDIR_READ = 8'h00;
    logic       iCLEAR = 1'b0;
    logic [7:0] oDATA_READ;
    logic       oRD_VALID;
    logic [7:0] oRECEIVE_BYTE_COUNT;
    logic       oRX_STATUS;
    logic       oRX_OVERFLOW;
    logic       oBUF_LOCKED;

    int errors = 0;
    int checks = 0;

    usb_rx_buffer dut (
        .CLK                 (CLK),
        .reset               (reset),
        .iWR_EN              (iWR_EN),
        .iDIR_WRITE          (iDIR_WRITE),
        .iDATA               (iDATA),
        .iMSG_END            (iMSG_END),
        .iRD_EN              (iRD_EN),
        .iDIR_READ           (iDIR_READ),
        .iCLEAR              (iCLEAR),
        .oDATA_READ          (oDATA_READ),
        .oRD_VALID           (oRD_VALID),
        .oRECEIVE_BYTE_COUNT (oRECEIVE_BYTE_COUNT),
        .oRX_STATUS          (oRX_STATUS),
        .oRX_OVERFLOW        (oRX_OVERFLOW),
        .oBUF_LOCKED         (oBUF_LOCKED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        iWR_EN = 1'b1; iDIR_WRITE = addr; iDATA = data;
        tick();
        iWR_EN = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr);
        iRD_EN = 1'b1; iDIR_READ = addr;
        tick();
        iRD_EN = 1'b0;
    endtask

    task automatic msg_end();
        iMSG_END = 1'b1;
        tick();
        iMSG_END = 1'b0;
    endtask

    task automatic clr();
        iCLEAR = 1'b1;
        tick();
        iCLEAR = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_count",  oRECEIVE_BYTE_COUNT, 8'd0);
        chk("rst_status", 8'(oRX_STATUS), 8'd0);
        chk("rst_ovf",    8'(oRX_OVERFLOW), 8'd0);
        chk("rst_locked", 8'(oBUF_LOCKED), 8'd0);
        chk("rst_valid",  8'(oRD_VALID), 8'd0);
        chk("rst_data",   oDATA_READ, 8'h00);

        rd(8'h30);
        chk("rd_cnt0_data",  oDATA_READ, 8'h00);
        chk("rd_cnt0_valid", 8'(oRD_VALID), 8'd1);
        tick();
        chk("rd_valid_pulse", 8'(oRD_VALID), 8'd0);

        // Three-byte message, then lock.
        wr(8'h31, 8'hA6);
        chk("cnt_after_1", oRECEIVE_BYTE_COUNT, 8'd1);
        wr(8'h32, 8'h41);
        wr(8'h33, 8'h12);
        chk("cnt_after_3", oRECEIVE_BYTE_COUNT, 8'd3);
        chk("filling_not_locked", 8'(oBUF_LOCKED), 8'd0);
        msg_end();
        chk("msg_status", 8'(oRX_STATUS), 8'd1);
        chk("msg_locked", 8'(oBUF_LOCKED), 8'd1);
        rd(8'h32);
        chk("rd_32", oDATA_READ, 8'h41);
        rd(8'h30);
        chk("rd_count_reg", oDATA_READ, 8'd3);
        rd(8'h34);
        chk("rd_beyond_count", oDATA_READ, 8'h00);

        wr(8'h34, 8'h55);
        chk("locked_wr_ovf", 8'(oRX_OVERFLOW), 8'd1);
        chk("locked_wr_cnt", oRECEIVE_BYTE_COUNT, 8'd3);
        chk("locked_still",  8'(oBUF_LOCKED), 8'd1);
        clr();
        chk("clr_count",  oRECEIVE_BYTE_COUNT, 8'd0);
        chk("clr_status", 8'(oRX_STATUS), 8'd0);
        chk("clr_ovf",    8'(oRX_OVERFLOW), 8'd0);
        chk("clr_locked", 8'(oBUF_LOCKED), 8'd0);

        // Full buffer and one past the end.
        for (int i = 0; i < 31; i++) wr(8'(8'h31 + i), 8'(8'h80 + i));
        chk("full_count", oRECEIVE_BYTE_COUNT, 8'd31);
        chk("full_no_ovf", 8'(oRX_OVERFLOW), 8'd0);
        wr(8'h50, 8'hEE);
        chk("past_end_ovf", 8'(oRX_OVERFLOW), 8'd1);
        chk("past_end_cnt", oRECEIVE_BYTE_COUNT, 8'd31);
        rd(8'h4F);
        chk("rd_last", oDATA_READ, 8'h9E);
        rd(8'h50);
        chk("rd_past_end", oDATA_READ, 8'h00);
        rd(8'h31);
        chk("rd_first", oDATA_READ, 8'h80);
        clr();

        // Out-of-order write raises count to highest offset+1.
        wr(8'h35, 8'h3C);
        chk("sparse_cnt", oRECEIVE_BYTE_COUNT, 8'd5);
        wr(8'h32, 8'h3D);
        chk("sparse_cnt_keep", oRECEIVE_BYTE_COUNT, 8'd5);
        clr();

        // Same-cycle read and write of one address returns the old byte.
        wr(8'h31, 8'h11);
        iRD_EN = 1'b1; iDIR_READ = 8'h31;
        wr(8'h31, 8'h22);
        iRD_EN = 1'b0;
        chk("rdw_old", oDATA_READ, 8'h11);
        rd(8'h31);
        chk("rdw_new", oDATA_READ, 8'h22);
        clr();

        msg_end();
        chk("empty_end_locked", 8'(oBUF_LOCKED), 8'd0);
        chk("empty_end_status", 8'(oRX_STATUS), 8'd0);

        iMSG_END = 1'b1;
        wr(8'h31, 8'h5A);
        iMSG_END = 1'b0;
        chk("wr_end_cnt",    oRECEIVE_BYTE_COUNT, 8'd1);
        chk("wr_end_locked", 8'(oBUF_LOCKED), 8'd1);
        rd(8'h31);
        chk("wr_end_data", oDATA_READ, 8'h5A);
        clr();

        // Clear beats a same-cycle write and message end.
        wr(8'h31, 8'h01);
        wr(8'h60, 8'h02);
        chk("oor_ovf_filling", 8'(oRX_OVERFLOW), 8'd1);
        iCLEAR = 1'b1; iMSG_END = 1'b1;
        wr(8'h32, 8'h77);
        iCLEAR = 1'b0; iMSG_END = 1'b0;
        chk("clr_wins_cnt",    oRECEIVE_BYTE_COUNT, 8'd0);
        chk("clr_wins_locked", 8'(oBUF_LOCKED), 8'd0);
        chk("clr_wins_ovf",    8'(oRX_OVERFLOW), 8'd0);

        // Release behaviour on reading the last byte of a locked message.
        wr(8'h31, 8'hA6); wr(8'h32, 8'h41); wr(8'h33, 8'h12);
        msg_end();
        rd(8'h33);
        chk("last_rd_data", oDATA_READ, 8'h12);
`ifdef RX_BUF_AUTO_RELEASE_EN
        chk("auto_rel_locked", 8'(oBUF_LOCKED), 8'd0);
        chk("auto_rel_status", 8'(oRX_STATUS), 8'd0);
        chk("auto_rel_cnt",    oRECEIVE_BYTE_COUNT, 8'd0);
`else
        chk("no_auto_locked", 8'(oBUF_LOCKED), 8'd1);
        chk("no_auto_status", 8'(oRX_STATUS), 8'd1);
        chk("no_auto_cnt",    oRECEIVE_BYTE_COUNT, 8'd3);
        clr();
`endif

        // Reset mid-message discards it.
        wr(8'h31, 8'h09); wr(8'h32, 8'h08);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_cnt",    oRECEIVE_BYTE_COUNT, 8'd0);
        chk("midrst_locked", 8'(oBUF_LOCKED), 8'd0);
        rd(8'h31);
        chk("midrst_rd", oDATA_READ, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
